// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement subtract: a + ~b + 1.
    localparam logic SUB_CARRY_IN = 1'b1;

endpackage

// File: rtl/full_adder_gate.sv
// Single 1-bit full-adder cell, time-shared by the serial controller.
module full_adder_gate (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell, LSB first,
// one bit per clock, with a start/ready/done handshake.
//
// state | meaning
// IDLE  | ready for a new operation; start accepts operands
// RUN   | serial loop, one bit per cycle for WIDTH cycles
// DONE  | one-cycle done pulse; sum/cout/ovf valid
module serial_add_ctrl
    import serial_arith_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               msb_cin_q, msb_cin_d;

    logic               fa_sum;
    logic               fa_cout;
    logic               accept;
    logic               last_bit;

    full_adder_gate u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .c    (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
    end

    // Visible result registers load only on the last RUN bit, so the
    // outputs stay stable while the working register shifts.
    always_comb begin
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        work_d    = work_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        msb_cin_d = msb_cin_q;
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = sub ? ~b : b;
            carry_d = sub ? SUB_CARRY_IN : cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            work_d  = {fa_sum, work_q[WIDTH-1:1]};
            carry_d = fa_cout;
            if (last_bit) begin
                sum_d     = {fa_sum, work_q[WIDTH-1:1]};
                cout_d    = fa_cout;
                msb_cin_d = carry_q;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            work_q    <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            msb_cin_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            work_q    <= work_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            msb_cin_q <= msb_cin_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = msb_cin_q ^ cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Waits at a falling edge until the DUT is idle (bounded).
    task automatic wait_ready();
        int guard;
        guard = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Issues one operation; lat is the cycle (accept cycle = 0) in which
    // done is seen, or -1 if it never arrives within the budget.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tcin, input logic tsub,
                          output int lat, output logic [7:0] rs,
                          output logic rc, output logic ro);
        wait_ready();
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tcin; sub = ~tsub;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        rs = sum; rc = cout; ro = ovf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        #12;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; logic [7:0] rs; logic rc, ro;
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, lat, rs, rc, ro);
        checks++; if (lat !== 9) begin failures++; $display("FAIL add1_latency got=%0d exp=9", lat); end
        checks++; if (rs !== 8'h96) begin failures++; $display("FAIL add1_sum got=%h exp=96", rs); end
        checks++; if (rc !== 1'b0) begin failures++; $display("FAIL add1_cout got=%b exp=0", rc); end
        checks++; if (ro !== 1'b1) begin failures++; $display("FAIL add1_ovf got=%b exp=1", ro); end
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, rs, rc, ro);
        checks++; if (rs !== 8'h00) begin failures++; $display("FAIL add2_sum got=%h exp=00", rs); end
        checks++; if (rc !== 1'b1) begin failures++; $display("FAIL add2_cout got=%b exp=1", rc); end
        checks++; if (ro !== 1'b0) begin failures++; $display("FAIL add2_ovf got=%b exp=0", ro); end
        run_op(8'h7F, 8'h00, 1'b1, 1'b0, lat, rs, rc, ro);
        checks++; if (rs !== 8'h80) begin failures++; $display("FAIL add3_sum got=%h exp=80", rs); end
        checks++; if (rc !== 1'b0) begin failures++; $display("FAIL add3_cout got=%b exp=0", rc); end
        checks++; if (ro !== 1'b1) begin failures++; $display("FAIL add3_ovf got=%b exp=1", ro); end
    endtask

    task automatic test_ignore_start();
        int done_cnt; logic [7:0] got_sum;
        done_cnt = 0; got_sum = 8'h00;
        wait_ready();
        a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 11; k++) begin
            checks++; if (ready !== (k >= 10)) begin failures++; $display("FAIL ign_ready_c%0d got=%b exp=%b", k, ready, (k >= 10)); end
            checks++; if (busy !== (k <= 8)) begin failures++; $display("FAIL ign_busy_c%0d got=%b exp=%b", k, busy, (k <= 8)); end
            checks++; if (done !== (k == 9)) begin failures++; $display("FAIL ign_done_c%0d got=%b exp=%b", k, done, (k == 9)); end
            if (done === 1'b1) begin done_cnt++; got_sum = sum; end
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
            if (k == 4) start = 1'b0;
            if (k < 11) begin @(posedge clk); #1; end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
        checks++; if (got_sum !== 8'h02) begin failures++; $display("FAIL ign_sum got=%h exp=02", got_sum); end
    endtask

    task automatic test_sub();
        int lat; logic [7:0] rs; logic rc, ro;
        run_op(8'h10, 8'h20, 1'b0, 1'b1, lat, rs, rc, ro);
        checks++; if (lat !== 9) begin failures++; $display("FAIL sub1_latency got=%0d exp=9", lat); end
        checks++; if (rs !== 8'hF0) begin failures++; $display("FAIL sub1_sum got=%h exp=f0", rs); end
        checks++; if (rc !== 1'b0) begin failures++; $display("FAIL sub1_cout got=%b exp=0", rc); end
        checks++; if (ro !== 1'b0) begin failures++; $display("FAIL sub1_ovf got=%b exp=0", ro); end
        // cin=0 must be ignored for subtract
        run_op(8'h80, 8'h01, 1'b0, 1'b1, lat, rs, rc, ro);
        checks++; if (rs !== 8'h7F) begin failures++; $display("FAIL sub2_sum got=%h exp=7f", rs); end
        checks++; if (rc !== 1'b1) begin failures++; $display("FAIL sub2_cout got=%b exp=1", rc); end
        checks++; if (ro !== 1'b1) begin failures++; $display("FAIL sub2_ovf got=%b exp=1", ro); end
    endtask

    task automatic test_reset_midrun();
        int lat, stray; logic [7:0] rs; logic rc, ro;
        stray = 0;
        wait_ready();
        a = 8'h55; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL mid_rst_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL mid_rst_cout got=%b exp=0", cout); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || ready !== 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL mid_rst_stray got=%0d exp=0", stray); end
        run_op(8'h03, 8'h04, 1'b0, 1'b0, lat, rs, rc, ro);
        checks++; if (lat !== 9) begin failures++; $display("FAIL post_rst_latency got=%0d exp=9", lat); end
        checks++; if (rs !== 8'h07) begin failures++; $display("FAIL post_rst_sum got=%h exp=07", rs); end
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        wait_ready();
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 31; k++) begin
            checks++; if (done !== (k == 9 || k == 19 || k == 29)) begin failures++; $display("FAIL b2b_done_c%0d got=%b exp=%b", k, done, (k == 9 || k == 19 || k == 29)); end
            if (done === 1'b1) begin
                ndone++;
                case (ndone)
                    1: begin
                        checks++; if (sum !== 8'h03) begin failures++; $display("FAIL b2b_sum1 got=%h exp=03", sum); end
                        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL b2b_cout1 got=%b exp=0", cout); end
                    end
                    2: begin
                        checks++; if (sum !== 8'h30) begin failures++; $display("FAIL b2b_sum2 got=%h exp=30", sum); end
                        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL b2b_cout2 got=%b exp=0", cout); end
                    end
                    3: begin
                        checks++; if (sum !== 8'h10) begin failures++; $display("FAIL b2b_sum3 got=%h exp=10", sum); end
                        checks++; if (cout !== 1'b1) begin failures++; $display("FAIL b2b_cout3 got=%b exp=1", cout); end
                    end
                    default: ;
                endcase
            end
            @(negedge clk);
            if (k == 1) begin a = 8'h10; b = 8'h20; end
            if (k == 11) begin a = 8'hF0; b = 8'h20; end
            if (k == 21) start = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (ndone !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ignore_start();
        test_sub();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
